if_stage_btb: RTL and testbench

- Instruction-fetch stage with a direct-mapped branch target buffer (BTB) and the IF/ID pipeline register.
- Holds the PC, drives the instruction-memory address and predicts next-PC from the BTB.
- Registers instruction, PC and prediction into IF/ID for the decode stage.
- Obeys pc_en / if_id_en / if_id_flush / modify_pc_ex from the hazard unit; the BTB is trained from the EX stage.

---
 rtl/if_stage_btb_pkg.sv | 37 +++
 rtl/if_stage_btb_if.sv | 38 +++
 rtl/if_stage_btb_btb.sv | 75 +++++++
 rtl/if_stage_btb.sv | 106 ++++++++++
 tb/tb_if_stage_btb.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/if_stage_btb_pkg.sv
// Shared constants and types for the fetch stage and its branch target buffer.
// The BTB is compiled in only when IF_BTB_EN is defined.
package if_stage_btb_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Bit 1 is the taken/not-taken direction; bit 0 marks the weak states.
  typedef enum logic [1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    STRONG_TAKEN     = 2'b10,
    WEAK_TAKEN       = 2'b11
  } btb_state_e;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
  } btb_pred_t;

  function automatic btb_state_e btb_next_state(input btb_state_e s, input logic taken);
    btb_state_e n;
    case (s)
      STRONG_NOT_TAKEN: n = taken ? WEAK_NOT_TAKEN : STRONG_NOT_TAKEN;
      WEAK_NOT_TAKEN:   n = taken ? WEAK_TAKEN     : STRONG_NOT_TAKEN;
      WEAK_TAKEN:       n = taken ? STRONG_TAKEN   : WEAK_NOT_TAKEN;
      default:          n = taken ? STRONG_TAKEN   : WEAK_TAKEN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/if_stage_btb_if.sv
// Bundle of hazard-unit controls, EX-stage redirect/BTB training, instruction
// memory port and IF/ID outputs of the fetch stage.
interface if_stage_btb_if;

  logic        pc_en;
  logic        if_id_en;
  logic        if_id_flush;
  logic        modify_pc_ex;
  logic [31:0] ex_redirect_pc;
  logic        btb_upd_en;
  logic [31:0] btb_upd_pc;
  logic        btb_upd_taken;
  logic [31:0] btb_upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_pred_taken;
  logic [31:0] if_id_pred_target;
  logic        if_id_valid;

  modport master (
    output pc_en, if_id_en, if_id_flush, modify_pc_ex, ex_redirect_pc,
    output btb_upd_en, btb_upd_pc, btb_upd_taken, btb_upd_target,
    output imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc, if_id_pred_taken,
    input  if_id_pred_target, if_id_valid
  );

  modport slave (
    input  pc_en, if_id_en, if_id_flush, modify_pc_ex, ex_redirect_pc,
    input  btb_upd_en, btb_upd_pc, btb_upd_taken, btb_upd_target,
    input  imem_rdata,
    output imem_addr, if_id_instr, if_id_pc, if_id_pred_taken,
    output if_id_pred_target, if_id_valid
  );

endinterface

// File: rtl/if_stage_btb_btb.sv
// Direct-mapped branch target buffer with 2-bit counters; instantiated by
// if_stage_btb only when IF_BTB_EN is defined.
module if_btb
  import if_stage_btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc_i,
  output btb_pred_t   pred_o,
  input  logic        upd_en_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  btb_state_e       state_q  [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             unused_lsb;

  assign lk_idx  = lookup_pc_i[IDX_W+1:2];
  assign lk_tag  = lookup_pc_i[31:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[31:IDX_W+2];
  assign unused_lsb = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  // Lookup reads the arrays before this edge's update: no write-to-read bypass.
  always_comb begin
    lk_hit       = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_o.taken = lk_hit && state_q[lk_idx][1];
    pred_o.target = pred_o.taken ? target_q[lk_idx] : lookup_pc_i + 32'd4;
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_en_i && upd_taken_i && !upd_hit) begin
      valid_q[upd_idx] <= 1'b1;
    end
  end

  // Payload arrays need no reset: an entry is ignored until its valid bit is set.
  always_ff @(posedge clk) begin
    if (upd_en_i) begin
      if (upd_hit) begin
        state_q[upd_idx] <= btb_next_state(state_q[upd_idx], upd_taken_i);
        if (upd_taken_i) begin
          target_q[upd_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target_i;
        state_q[upd_idx]  <= WEAK_TAKEN;
      end
    end
  end

endmodule

// File: rtl/if_stage_btb.sv
// Instruction-fetch stage: PC register, optional BTB prediction (IF_BTB_EN)
// and the IF/ID pipeline register.
module if_stage_btb
  import if_stage_btb_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned BTB_IDX_W   = 4
) (
  input logic          clk,
  input logic          rst,
  if_stage_btb_if.slave bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  btb_pred_t   pred;

  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        pt_q, pt_d;
  logic [31:0] ptgt_q, ptgt_d;
  logic        valid_q, valid_d;

  assign pc_plus4 = pc_q + 32'd4;

`ifdef IF_BTB_EN
  if_btb #(
    .ENTRIES(BTB_ENTRIES),
    .IDX_W  (BTB_IDX_W)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc_i (pc_q),
    .pred_o      (pred),
    .upd_en_i    (bus.btb_upd_en),
    .upd_pc_i    (bus.btb_upd_pc),
    .upd_taken_i (bus.btb_upd_taken),
    .upd_target_i(bus.btb_upd_target)
  );
`else
  logic unused_btb;

  assign pred.taken  = 1'b0;
  assign pred.target = '0;
  assign unused_btb  = ^{bus.btb_upd_en, bus.btb_upd_pc, bus.btb_upd_taken,
                         bus.btb_upd_target, 32'(BTB_ENTRIES), 32'(BTB_IDX_W)};
`endif

  // Redirect from EX wins even while the hazard unit stalls the PC.
  always_comb begin
    pc_d = pc_q;
    if (bus.modify_pc_ex) begin
      pc_d = bus.ex_redirect_pc;
    end else if (bus.pc_en) begin
      pc_d = pred.taken ? pred.target : pc_plus4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    pt_d    = pt_q;
    ptgt_d  = ptgt_q;
    valid_d = valid_q;
    if (bus.if_id_flush || bus.modify_pc_ex) begin
      instr_d = NOP_INSTR;
      id_pc_d = '0;
      pt_d    = 1'b0;
      ptgt_d  = '0;
      valid_d = 1'b0;
    end else if (bus.if_id_en) begin
      instr_d = bus.imem_rdata;
      id_pc_d = pc_q;
      pt_d    = pred.taken;
      ptgt_d  = pred.target;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      id_pc_q <= '0;
      pt_q    <= 1'b0;
      ptgt_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      pt_q    <= pt_d;
      ptgt_q  <= ptgt_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr         = pc_q;
  assign bus.if_id_instr       = instr_q;
  assign bus.if_id_pc          = id_pc_q;
  assign bus.if_id_pred_taken  = pt_q;
  assign bus.if_id_pred_target = ptgt_q;
  assign bus.if_id_valid       = valid_q;

endmodule

// File: tb/tb_if_stage_btb.sv
// Directed bench for if_stage_btb: vector table for sequencing/stall/redirect,
// hand sequences for BTB training, aliasing and async reset.
module tb_if_stage_btb;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] KEY = 32'h5A5A0000;
`ifdef IF_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  if_stage_btb_if bus ();

  if_stage_btb #(
    .RESET_PC   (32'h00000000),
    .BTB_ENTRIES(16),
    .BTB_IDX_W  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Instruction memory: word content derived from its address.
  assign bus.imem_rdata = bus.imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        pe, ie, fl, md;
    logic [31:0] rd;
    logic [31:0] e_pc, e_idpc;
    logic        e_v;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] nt_tgt(input logic v, input logic [31:0] idpc);
    return (BTB_ON && v) ? idpc + 32'd4 : 32'h0;
  endfunction

  task automatic expect_out(input string nm, input logic [31:0] pc, input logic [31:0] idpc,
                            input logic v, input logic pt, input logic [31:0] tg);
    chk({nm, ".pc"},     bus.imem_addr, pc);
    chk({nm, ".id_pc"},  bus.if_id_pc, idpc);
    chk({nm, ".valid"},  32'(bus.if_id_valid), 32'(v));
    chk({nm, ".instr"},  bus.if_id_instr, v ? (idpc ^ KEY) : NOP);
    chk({nm, ".pt"},     32'(bus.if_id_pred_taken), 32'(pt));
    chk({nm, ".ptgt"},   bus.if_id_pred_target, tg);
  endtask

  task automatic cyc(input logic pe, input logic ie, input logic fl, input logic md,
                     input logic [31:0] rd, input logic ue, input logic [31:0] up,
                     input logic ut, input logic [31:0] ug);
    bus.pc_en          = pe;
    bus.if_id_en       = ie;
    bus.if_id_flush    = fl;
    bus.modify_pc_ex   = md;
    bus.ex_redirect_pc = rd;
    bus.btb_upd_en     = ue;
    bus.btb_upd_pc     = up;
    bus.btb_upd_taken  = ut;
    bus.btb_upd_target = ug;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run();
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic redir(input logic [31:0] a);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic stall_upd(input logic [31:0] p, input logic t, input logic [31:0] g);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, p, t, g);
  endtask

  initial begin
    logic [31:0] tk_pc, tk_tg;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.pc_en = 1'b0; bus.if_id_en = 1'b0; bus.if_id_flush = 1'b0;
    bus.modify_pc_ex = 1'b0; bus.ex_redirect_pc = '0;
    bus.btb_upd_en = 1'b0; bus.btb_upd_pc = '0; bus.btb_upd_taken = 1'b0;
    bus.btb_upd_target = '0;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h10,       32'hC,        1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       32'hC,        1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h14,       32'h10,       1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h18,       32'h14,       1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h100,      32'h100,      32'h0,        1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h104,      32'h100,      1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        32'h108,      32'h0,        1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'h108,      32'h108,      1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h10C,      32'h108,      1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'h0,        1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFC, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h20,       32'h20,       32'h0,        1'b0};

    #2 rst = 1'b1;
    #1 expect_out("reset", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].pe, tbl[i].ie, tbl[i].fl, tbl[i].md, tbl[i].rd, 1'b0, 32'h0, 1'b0, 32'h0);
      expect_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_idpc, tbl[i].e_v,
                 1'b0, nt_tgt(tbl[i].e_v, tbl[i].e_idpc));
    end

    // A taken prediction of 0x20 lands on 0x80 only when the BTB is present.
    tk_pc = BTB_ON ? 32'h80 : 32'h24;
    tk_tg = BTB_ON ? 32'h80 : 32'h0;

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h80);
    expect_out("same_cycle_upd", 32'h24, 32'h20, 1'b1, 1'b0, nt_tgt(1'b1, 32'h20));
    redir(32'h20);
    run();
    expect_out("train_wt", tk_pc, 32'h20, 1'b1, BTB_ON, tk_tg);

    stall_upd(32'h20, 1'b1, 32'h80);
    stall_upd(32'h20, 1'b1, 32'h80);
    expect_out("stall_hold", tk_pc, 32'h20, 1'b1, BTB_ON, tk_tg);
    stall_upd(32'h20, 1'b0, 32'h0);
    redir(32'h20);
    run();
    expect_out("st_to_wt", tk_pc, 32'h20, 1'b1, BTB_ON, tk_tg);

    stall_upd(32'h20, 1'b0, 32'h0);
    redir(32'h20);
    run();
    expect_out("wt_to_wnt", 32'h24, 32'h20, 1'b1, 1'b0, nt_tgt(1'b1, 32'h20));

    stall_upd(32'h20, 1'b1, 32'h80);
    redir(32'h20);
    run();
    expect_out("wnt_to_wt", tk_pc, 32'h20, 1'b1, BTB_ON, tk_tg);

    stall_upd(32'h60, 1'b1, 32'h200);
    stall_upd(32'hA0, 1'b0, 32'h0);
    redir(32'h20);
    run();
    expect_out("alias_evict", 32'h24, 32'h20, 1'b1, 1'b0, nt_tgt(1'b1, 32'h20));
    redir(32'h60);
    run();
    expect_out("alias_new", BTB_ON ? 32'h200 : 32'h64, 32'h60, 1'b1, BTB_ON,
               BTB_ON ? 32'h200 : 32'h0);

    // Async reset with a BTB update pending across the reset edge.
    bus.btb_upd_en = 1'b1; bus.btb_upd_pc = 32'h60;
    bus.btb_upd_taken = 1'b1; bus.btb_upd_target = 32'h300;
    #2 rst = 1'b1;
    #1 expect_out("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.btb_upd_en = 1'b0;
    redir(32'h60);
    run();
    expect_out("btb_cleared", 32'h64, 32'h60, 1'b1, 1'b0, nt_tgt(1'b1, 32'h60));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
